pc_redirect_gen: RTL and testbench

Fetch-side program-counter generator that consumes the EX-stage branch resolution (taken flag plus target PC) and produces the IF fetch address. It owns the PC register, sequential advance and stall hold. It also holds a pending redirect while instruction memory is not ready, generates pipeline flushes on a taken control transfer, and traps misaligned targets. It sits between the EX branch unit and the IF stage / instruction memory port.

---
 rtl/pc_redirect_gen_pkg.sv | 15 +
 rtl/pc_redirect_gen.sv | 108 ++++++++++
 tb/tb_pc_redirect_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_gen_pkg.sv
// Shared fetch-side types and constants for the PC redirect generator.
package pc_redirect_gen_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_RUN,
    PC_HOLD,
    PC_HALT
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_gen.sv
// IF fetch-address generator: sequential advance, stall hold, pending redirect
// while imem is busy, taken-transfer flushes and misaligned-target trap.
import pc_redirect_gen_pkg::*;

module pc_redirect_gen #(
  parameter int              XLEN     = pc_redirect_gen_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            is_taken,
  input  logic [XLEN-1:0] pc_bru,
  input  logic            stall,
  input  logic            if_ready,
  output logic [XLEN-1:0] pc_if,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            redirect_pending,
  output logic            misalign_err
);

  pc_state_e       state;
  logic [XLEN-1:0] pend;
  logic            redirect;
  logic            aligned;

  assign redirect         = ex_valid & is_taken;
  assign aligned          = (pc_bru[1:0] == 2'b00);
  assign pc_plus4         = pc_if + XLEN'(INSN_BYTES);
  assign redirect_pending = (state == PC_HOLD);

  always_comb begin
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst) begin
      unique case (state)
        PC_RUN: begin
          flush_if_id = redirect;
          flush_id_ex = redirect;
        end
        PC_HOLD: begin
          flush_if_id = 1'b1;
          flush_id_ex = redirect;
        end
        default: begin
          flush_if_id = 1'b0;
          flush_id_ex = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_if        <= RESET_PC;
      pc_valid     <= 1'b0;
      state        <= PC_RUN;
      pend         <= '0;
      misalign_err <= 1'b0;
    end else begin
      unique case (state)
        PC_RUN: begin
          if (redirect && !aligned) begin
            misalign_err <= 1'b1;
            pc_valid     <= 1'b0;
            state        <= PC_HALT;
          end else if (redirect) begin
            if (if_ready) begin
              pc_if    <= pc_bru;
              pc_valid <= 1'b1;
            end else begin
              pend     <= pc_bru;
              pc_valid <= 1'b0;
              state    <= PC_HOLD;
            end
          // Advance only once the current address has been presented as valid.
          end else if (stall || !if_ready || !pc_valid) begin
            pc_valid <= 1'b1;
          end else begin
            pc_if <= pc_plus4;
          end
        end
        PC_HOLD: begin
          if (redirect && !aligned) begin
            misalign_err <= 1'b1;
            pc_valid     <= 1'b0;
            state        <= PC_HALT;
          end else if (if_ready) begin
            // A redirect arriving in the release cycle is the latest target.
            pc_if    <= redirect ? pc_bru : pend;
            pc_valid <= 1'b1;
            state    <= PC_RUN;
          end else if (redirect) begin
            pend <= pc_bru;
          end
        end
        default: begin
          pc_valid     <= 1'b0;
          misalign_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_gen.sv
// Directed table-driven bench for pc_redirect_gen.
module tb_pc_redirect_gen;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        is_taken;
  logic [31:0] pc_bru;
  logic        stall;
  logic        if_ready;
  logic [31:0] pc_if;
  logic        pc_valid;
  logic [31:0] pc_plus4;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_pending;
  logic        misalign_err;

  int tests  = 0;
  int failed = 0;

  pc_redirect_gen #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .is_taken        (is_taken),
    .pc_bru          (pc_bru),
    .stall           (stall),
    .if_ready        (if_ready),
    .pc_if           (pc_if),
    .pc_valid        (pc_valid),
    .pc_plus4        (pc_plus4),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .redirect_pending(redirect_pending),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ex_valid;
    logic        is_taken;
    logic [31:0] pc_bru;
    logic        stall;
    logic        if_ready;
    logic        fl_ifid;
    logic        fl_idex;
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic t,
                              input logic [31:0] b, input logic s, input logic y,
                              input logic fi, input logic fe, input logic [31:0] p,
                              input logic v, input logic pd, input logic m);
    vec_t x;
    x.rst = r; x.ex_valid = e; x.is_taken = t; x.pc_bru = b; x.stall = s;
    x.if_ready = y; x.fl_ifid = fi; x.fl_idex = fe; x.pc = p; x.valid = v;
    x.pend = pd; x.mis = m;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s [step %0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive after the falling edge, check flushes before the rising edge,
  // check registered state 1 time unit after it.
  task automatic apply(input vec_t v, input int idx);
    rst = v.rst; ex_valid = v.ex_valid; is_taken = v.is_taken;
    pc_bru = v.pc_bru; stall = v.stall; if_ready = v.if_ready;
    #1;
    chk("flush_if_id", idx, 32'(flush_if_id), 32'(v.fl_ifid));
    chk("flush_id_ex", idx, 32'(flush_id_ex), 32'(v.fl_idex));
    @(posedge clk);
    #1;
    chk("pc_if", idx, pc_if, v.pc);
    chk("pc_valid", idx, 32'(pc_valid), 32'(v.valid));
    chk("redirect_pending", idx, 32'(redirect_pending), 32'(v.pend));
    chk("misalign_err", idx, 32'(misalign_err), 32'(v.mis));
    chk("pc_plus4", idx, pc_plus4, v.pc + 32'd4);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; is_taken = 1'b0; pc_bru = '0;
    stall = 1'b0; if_ready = 1'b1;

    //          rst e t pc_bru         s y  fi fe pc             v pd m
    vecs.push_back(mk(1, 0,0,32'h0,        0,1, 0,0, 32'h0,        0,0,0)); // 0
    vecs.push_back(mk(1, 0,0,32'h0,        0,1, 0,0, 32'h0,        0,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h0,        1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h4,        1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h8,        1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'hC,        1,0,0)); // 5
    vecs.push_back(mk(0, 1,0,32'h500,      0,1, 0,0, 32'h10,       1,0,0));
    vecs.push_back(mk(0, 1,1,32'h100,      1,1, 1,1, 32'h100,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h200,      1,1, 1,1, 32'h200,      1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h204,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h300,      0,0, 1,1, 32'h204,      0,1,0)); // 10
    vecs.push_back(mk(0, 0,0,32'h0,        0,0, 1,0, 32'h204,      0,1,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,0, 1,0, 32'h204,      0,1,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 1,0, 32'h300,      1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h304,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h400,      0,0, 1,1, 32'h304,      0,1,0)); // 15
    vecs.push_back(mk(0, 1,1,32'h480,      0,0, 1,1, 32'h304,      0,1,0));
    vecs.push_back(mk(0, 0,0,32'h0,        1,1, 1,0, 32'h480,      1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        1,1, 0,0, 32'h480,      1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,0, 0,0, 32'h480,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'hFFFF_FFF8,0,1, 1,1, 32'hFFFF_FFF8,1,0,0)); // 20
    vecs.push_back(mk(0, 0,0,32'h0,        1,1, 0,0, 32'hFFFF_FFF8,1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        1,1, 0,0, 32'hFFFF_FFF8,1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        1,1, 0,0, 32'hFFFF_FFF8,1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'hFFFF_FFFC,1,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h0,        1,0,0)); // 25
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h4,        1,0,0));
    vecs.push_back(mk(0, 1,1,32'h202,      0,1, 1,1, 32'h4,        0,0,1));
    // after the HALT dwell
    vecs.push_back(mk(1, 1,1,32'h700,      0,0, 0,0, 32'h0,        0,0,0)); // 28
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h0,        1,0,0));
    vecs.push_back(mk(0, 1,1,32'h800,      0,0, 1,1, 32'h0,        0,1,0)); // 30
    vecs.push_back(mk(1, 0,0,32'h0,        0,0, 0,0, 32'h0,        0,0,0));
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h0,        1,0,0));
    vecs.push_back(mk(0, 1,1,32'h900,      0,0, 1,1, 32'h0,        0,1,0));
    vecs.push_back(mk(0, 1,1,32'h903,      0,0, 1,1, 32'h0,        0,0,1));
    vecs.push_back(mk(1, 0,0,32'h0,        0,1, 0,0, 32'h0,        0,0,0)); // 35
    vecs.push_back(mk(0, 0,0,32'h0,        0,1, 0,0, 32'h0,        1,0,0));

    @(negedge clk);
    for (int i = 0; i <= 27; i++) apply(vecs[i], i);

    // HALT dwell: frozen PC, no flushes even with taken redirects presented.
    for (int k = 0; k < 10; k++) begin
      apply(mk(0, (k % 2 == 1), 1'b1, 32'h600, 1'b0, 1'b1,
               0, 0, 32'h4, 0, 0, 1), 100 + k);
    end

    for (int i = 28; i < vecs.size(); i++) apply(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
